// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between control unit / ALU and the PC sequencer.
// The master drives the control inputs; the slave (sequencer) returns PC state.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             Branch;
  logic             Branch_ULA;
  logic [WIDTH-1:0] PC_next_I;
  logic             Jump;
  logic [WIDTH-1:0] Jump_target;
  logic             Stall;
  logic             Halt;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_Branch;
  logic             Fetch_en;
  logic             Flush;
  logic             Halted;
  logic [15:0]      Redirect_count;

  modport master (
    output Branch, Branch_ULA, PC_next_I, Jump, Jump_target, Stall, Halt,
    input  PC, PC_Branch, Fetch_en, Flush, Halted, Redirect_count
  );

  modport slave (
    input  Branch, Branch_ULA, PC_next_I, Jump, Jump_target, Stall, Halt,
    output PC, PC_Branch, Fetch_en, Flush, Halted, Redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: picks next PC (branch/jump/hold/increment), flushes
// wrong-path fetches after a redirect and stops fetch on halt.
module pc_sequencer #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      FLUSH_DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_DEPTH);

  typedef enum logic [1:0] {StInit, StRun, StFlush, StHalted} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_pc, w_pc_next;
  logic             r_fetch_en, w_fetch_en_next;
  logic [2:0]       r_flush_cnt, w_flush_cnt_next;
  logic [15:0]      r_redirect_count, w_redirect_count_next;
  logic             w_taken_br, w_redirect;

  assign w_taken_br = bus.Branch & bus.Branch_ULA;
  assign w_redirect = w_taken_br | bus.Jump;

  always_comb begin
    w_state_next          = r_state;
    w_pc_next             = r_pc;
    w_flush_cnt_next      = r_flush_cnt;
    w_redirect_count_next = r_redirect_count;
    unique case (r_state)
      StInit: w_state_next = StRun;
      StRun, StFlush: begin
        if (w_redirect) begin
          // Branch in EX is older than a jump in ID, so it wins.
          w_pc_next        = w_taken_br ? bus.PC_next_I : bus.Jump_target;
          w_flush_cnt_next = FlushLoad;
          w_state_next     = StFlush;
          if (r_redirect_count != 16'hFFFF) begin
            w_redirect_count_next = r_redirect_count + 16'd1;
          end
        end else if (bus.Halt && (r_state == StRun)) begin
          w_state_next = StHalted;
        end else begin
          if (!bus.Stall) begin
            w_pc_next = r_pc + WIDTH'(1);
          end
          // Flush countdown ignores Stall; a halt seen here is wrong-path.
          if (r_state == StFlush) begin
            w_flush_cnt_next = r_flush_cnt - 3'd1;
            if (r_flush_cnt == 3'd1) begin
              w_state_next = StRun;
            end
          end
        end
      end
      default: ;
    endcase
    w_fetch_en_next = (w_state_next == StRun) || (w_state_next == StFlush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= StInit;
      r_pc             <= RESET_PC;
      r_fetch_en       <= 1'b0;
      r_flush_cnt      <= 3'd0;
      r_redirect_count <= 16'd0;
    end else begin
      r_state          <= w_state_next;
      r_pc             <= w_pc_next;
      r_fetch_en       <= w_fetch_en_next;
      r_flush_cnt      <= w_flush_cnt_next;
      r_redirect_count <= w_redirect_count_next;
    end
  end

  assign bus.PC             = r_pc;
  assign bus.PC_Branch      = w_pc_next;
  assign bus.Fetch_en       = r_fetch_en;
  assign bus.Flush          = (r_flush_cnt != 3'd0);
  assign bus.Halted         = (r_state == StHalted);
  assign bus.Redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, random run against a
// behavioural model, counter saturation and a narrow-width wrap instance.
module tb_pc_sequencer;

  localparam logic [31:0] RstPc = 32'h10;
  localparam int          Depth = 2;

  logic clk = 1'b0;
  logic rst32, rst4;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus32 ();
  pc_sequencer_if #(.WIDTH(4))  bus4 ();

  pc_sequencer #(.WIDTH(32), .RESET_PC(RstPc), .FLUSH_DEPTH(Depth)) dut32 (
    .clk(clk), .reset(rst32), .bus(bus32)
  );

  pc_sequencer #(.WIDTH(4), .RESET_PC(4'hE), .FLUSH_DEPTH(3)) dut4 (
    .clk(clk), .reset(rst4), .bus(bus4)
  );

  typedef struct {
    logic        rst, br, ula;
    logic [31:0] ni;
    logic        jmp;
    logic [31:0] jt;
    logic        stall, halt;
    logic [31:0] e_pc;
    logic        e_fetch, e_flush, e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, br, ula, input logic [31:0] ni,
                              input logic jmp, input logic [31:0] jt,
                              input logic stall, halt, input logic [31:0] e_pc,
                              input logic e_fetch, e_flush, e_halted,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.br = br; v.ula = ula; v.ni = ni; v.jmp = jmp; v.jt = jt;
    v.stall = stall; v.halt = halt; v.e_pc = e_pc; v.e_fetch = e_fetch;
    v.e_flush = e_flush; v.e_halted = e_halted; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, br, ula, input logic [31:0] ni, input logic jmp,
                       input logic [31:0] jt, input logic stall, halt);
    rst32 = rst; bus32.Branch = br; bus32.Branch_ULA = ula; bus32.PC_next_I = ni;
    bus32.Jump = jmp; bus32.Jump_target = jt; bus32.Stall = stall; bus32.Halt = halt;
  endtask

  // Behavioural model: started = past the post-reset cycle, flush_left = cycles of Flush owed.
  logic [31:0] m_pc;
  bit          m_started, m_halted;
  int          m_flush_left, m_cnt;

  function automatic logic [31:0] model_pcb();
    logic [31:0] r;
    if (!m_started || m_halted) r = m_pc;
    else if (bus32.Branch && bus32.Branch_ULA) r = bus32.PC_next_I;
    else if (bus32.Jump) r = bus32.Jump_target;
    else if (bus32.Halt && m_flush_left == 0) r = m_pc;
    else if (bus32.Stall) r = m_pc;
    else r = m_pc + 32'd1;
    return r;
  endfunction

  task automatic model_step();
    logic [31:0] nxt;
    bit redir;
    nxt   = model_pcb();
    redir = (bus32.Branch && bus32.Branch_ULA) || bus32.Jump;
    if (rst32) begin
      m_pc = RstPc; m_started = 0; m_halted = 0; m_flush_left = 0; m_cnt = 0;
    end else if (!m_halted) begin
      if (!m_started) m_started = 1;
      else if (redir) begin
        m_flush_left = Depth;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else if (bus32.Halt && m_flush_left == 0) m_halted = 1;
      else if (m_flush_left > 0) m_flush_left--;
      m_pc = nxt;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"}, 64'(bus32.PC), 64'(m_pc));
    check({tag, " fetch"}, 64'(bus32.Fetch_en), 64'(m_started && !m_halted));
    check({tag, " flush"}, 64'(bus32.Flush), 64'(m_flush_left > 0));
    check({tag, " halted"}, 64'(bus32.Halted), 64'(m_halted));
    check({tag, " cnt"}, 64'(bus32.Redirect_count), 64'(m_cnt));
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    rst4 = 1; bus4.Branch = 0; bus4.Branch_ULA = 0; bus4.PC_next_I = 0;
    bus4.Jump = 0; bus4.Jump_target = 0; bus4.Stall = 0; bus4.Halt = 0;

    //            rst br ula ni     jmp jt     st ht  pc     fe fl ha cnt
    vecs.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0, 'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h11, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h12, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     1, 'h1E,  0, 0, 'h1E, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h1F, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h20, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 'h80,  0, 0,     0, 0, 'h80, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h81, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h82, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 'h55,  0, 0,     0, 0, 'h83, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 'h40,  1, 'h90,  0, 0, 'h40, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,     1, 'h90,  0, 0, 'h90, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h91, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h92, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0,     1, 'h05,  0, 0, 'h05, 1, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     1, 0, 'h05, 1, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     1, 1, 'h05, 1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     1, 0, 'h05, 1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h06, 1, 0, 0, 5));
    vecs.push_back(mk(0, 1, 1, 'h30,  0, 0,     1, 0, 'h30, 1, 1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h31, 1, 1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h32, 1, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0,     1, 'h05,  0, 1, 'h05, 1, 1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h06, 1, 1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h07, 1, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 1, 'h07, 0, 0, 1, 7));
    vecs.push_back(mk(0, 1, 1, 'h99,  1, 'h33,  1, 1, 'h07, 0, 0, 1, 7));
    vecs.push_back(mk(0, 0, 0, 0,     1, 'h44,  0, 0, 'h07, 0, 0, 1, 7));
    vecs.push_back(mk(1, 0, 0, 0,     0, 0,     0, 0, 'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0, 'h11, 1, 0, 0, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].ula, vecs[i].ni, vecs[i].jmp, vecs[i].jt,
            vecs[i].stall, vecs[i].halt);
      @(posedge clk); #1;
      check($sformatf("vec%0d pc", i), 64'(bus32.PC), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d fetch", i), 64'(bus32.Fetch_en), 64'(vecs[i].e_fetch));
      check($sformatf("vec%0d flush", i), 64'(bus32.Flush), 64'(vecs[i].e_flush));
      check($sformatf("vec%0d halted", i), 64'(bus32.Halted), 64'(vecs[i].e_halted));
      check($sformatf("vec%0d cnt", i), 64'(bus32.Redirect_count), 64'(vecs[i].e_cnt));
    end

    // Random run against the model, starting from reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    check_model("rnd reset");
    for (int n = 0; n < 3000; n++) begin
      drive((m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0)),
            ($urandom_range(0, 3) == 0), 1'($urandom), $urandom,
            ($urandom_range(0, 5) == 0), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));
      #1;
      check($sformatf("rnd%0d pc_branch", n), 64'(bus32.PC_Branch), 64'(model_pcb()));
      model_step();
      @(posedge clk); #1;
      check_model($sformatf("rnd%0d", n));
    end

    // Redirect counter saturation.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 1; n <= 65536; n++) begin
      drive(0, 0, 0, 0, 1, 32'(n), 0, 0);
      @(posedge clk); #1;
      if (n == 65534) check("sat 65534", 64'(bus32.Redirect_count), 64'hFFFE);
      if (n == 65535) check("sat 65535", 64'(bus32.Redirect_count), 64'hFFFF);
    end
    check("sat 65536", 64'(bus32.Redirect_count), 64'hFFFF);
    check("sat pc", 64'(bus32.PC), 64'h10000);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Narrow instance: wrap and a 3-deep flush.
    rst4 = 1;
    @(posedge clk); #1;
    check("w4 reset pc", 64'(bus4.PC), 64'hE);
    check("w4 reset fetch", 64'(bus4.Fetch_en), 64'h0);
    rst4 = 0;
    @(posedge clk); #1;
    check("w4 init pc", 64'(bus4.PC), 64'hE);
    @(posedge clk); #1;
    check("w4 pc F", 64'(bus4.PC), 64'hF);
    check("w4 pc_branch wrap", 64'(bus4.PC_Branch), 64'h0);
    @(posedge clk); #1;
    check("w4 wrap pc", 64'(bus4.PC), 64'h0);
    bus4.Jump = 1; bus4.Jump_target = 4'hF;
    @(posedge clk); #1;
    bus4.Jump = 0;
    check("w4 jump pc", 64'(bus4.PC), 64'hF);
    check("w4 flush1", 64'(bus4.Flush), 64'h1);
    @(posedge clk); #1;
    check("w4 flush2", 64'(bus4.Flush), 64'h1);
    check("w4 flush wrap pc", 64'(bus4.PC), 64'h0);
    @(posedge clk); #1;
    check("w4 flush3", 64'(bus4.Flush), 64'h1);
    @(posedge clk); #1;
    check("w4 flush done", 64'(bus4.Flush), 64'h0);
    check("w4 final pc", 64'(bus4.PC), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and sequences instruction fetch.
- Each cycle it selects the next PC from four sources: PC+1, a taken-branch target, a jump target, or the held value on stall.
- After any redirect it flushes the wrong-path instructions already in the pipe, and it stops fetch on a halt.
- Sits between the control unit, the ALU branch-equal output and instruction memory; it replaces the free-running PC register plus branch mux.

Parameters:
WIDTH, 32, PC width in bits; PC is word-addressed and increments by 1.
RESET_PC, 0, PC value loaded on reset.
FLUSH_DEPTH, 2, number of cycles Flush is held after a redirect (1..7).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
Branch  input  1  control-unit branch instruction in EX.
Branch_ULA  input  1  ALU equal flag for the instruction in EX.
PC_next_I  input  WIDTH  branch target (PC + extended immediate), valid with Branch.
Jump  input  1  control-unit jump instruction in ID.
Jump_target  input  WIDTH  jump target, valid with Jump.
Stall  input  1  hazard unit request to hold PC.
Halt  input  1  halt instruction decoded in ID.
PC  output  WIDTH  current fetch address (registered).
PC_Branch  output  WIDTH  combinational next-PC value that will load at the next edge.
Fetch_en  output  1  instruction memory read enable (registered).
Flush  output  1  kill IF/ID contents (registered).
Halted  output  1  high while in HALTED state.
Redirect_count  output  16  count of taken redirects, saturating at 16'hFFFF.

Behaviour:
- Reset: all synchronous on the clk edge where reset=1; reset overrides everything, including mid-flush and HALTED.
  - Reset values: PC=RESET_PC, Fetch_en=0, Flush=0, Halted=0, Redirect_count=0, flush counter=0, state=INIT.
- States: INIT, RUN, FLUSH, HALTED.
- INIT: lasts one cycle. PC holds RESET_PC; next state is RUN with Fetch_en=1. All other inputs are ignored.
- Source definitions:
  - taken_br = Branch & Branch_ULA.
  - redirect = taken_br | Jump.
- Priority in RUN and FLUSH, highest first: taken_br > Jump > Halt > Stall > increment.
  - taken_br: PC_Branch = PC_next_I. A branch in EX is older than a jump in ID, so the branch wins and the jump is discarded.
  - Jump: PC_Branch = Jump_target.
  - Stall (no redirect): PC_Branch = PC.
  - Otherwise: PC_Branch = PC + 1, wrapping modulo 2^WIDTH (all-ones + 1 = 0).
- Redirect handling:
  - On the redirect edge: PC loads the target, flush counter loads FLUSH_DEPTH, state goes to FLUSH, Redirect_count increments unless saturated.
  - Flush is 1 exactly while the counter is nonzero, i.e. for FLUSH_DEPTH cycles starting the cycle after the redirect edge.
- FLUSH state:
  - PC keeps advancing from the new target; Fetch_en stays 1.
  - The counter decrements every cycle regardless of Stall.
  - Stall still holds PC.
  - A new redirect during FLUSH reloads the counter to FLUSH_DEPTH and counts again.
  - Halt is ignored in FLUSH (it is a wrong-path instruction).
  - When the counter reaches 0 and there is no redirect, the next state is RUN.
- Halt:
  - In RUN with no redirect: the next state is HALTED. PC is held at its current value and is not incremented; Fetch_en=0 and Halted=1 from the next cycle.
  - A Halt coincident with a redirect is ignored.
  - HALTED: all inputs are ignored; only reset exits.
- Stall in RUN with no redirect or Halt: PC holds, Fetch_en stays 1, state stays RUN.
- PC_Branch is purely combinational from the current state and inputs; in HALTED and INIT it equals PC.

Test Plan:
- Reset with RESET_PC=0x10 -> PC=0x10, Fetch_en=0 for 1 cycle; then PC steps 0x10, 0x11, 0x12 with Fetch_en=1, Flush=0.
- At PC=0x20 drive Branch=1, Branch_ULA=1, PC_next_I=0x80 for one cycle -> next PC=0x80, then 0x81; Flush=1 for exactly 2 cycles; Redirect_count=1. Repeat with Branch_ULA=0 -> PC=0x21, no Flush.
- Same cycle Branch&Branch_ULA (target 0x40) and Jump (target 0x90) -> PC=0x40, Redirect_count increments by 1 only. During the resulting flush, a Jump to 0x90 -> PC=0x90 and Flush extends for 2 further cycles.
- Stall=1 for 3 cycles at PC=0x05 -> PC stays 0x05; release -> 0x06. Stall concurrent with a taken branch to 0x30 -> PC=0x30.
- Halt at PC=0x07 in RUN -> Halted=1, Fetch_en=0, PC frozen at 0x07 despite Branch/Jump/Stall activity. Halt during FLUSH or coincident with a Jump -> ignored. Reset while HALTED -> INIT, PC=RESET_PC.
- WIDTH=4, PC=0xF with no events -> PC=0x0. Force 65536 redirects -> Redirect_count holds at 0xFFFF.
